key_action_queue: RTL
=====================

# key_action_queue

Sits directly downstream of the PS/2 press driver in the Squares input path. It translates the driver's one-cycle `{valid, makeBreak, outCode}` events into game actions, keeps a held-key bitmap, and buffers press actions in a small show-ahead FIFO. The game logic pops these actions at its own pace. Optional auto-repeat re-issues a held direction at a fixed rate.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `REPEAT_FIRST`, 12_500_000: cycles from press to first repeat (250 ms at 50 MHz).
- `REPEAT_NEXT`, 5_000_000: cycles between subsequent repeats (100 ms).

- `CLOCK_50`  in  1  sole clock; all state on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  one-cycle key event strobe from press driver.
- `makeBreak`  in  1  1 = press (make), 0 = release (break); qualified by `valid`.
- `outCode`  in  8  scan code; qualified by `valid`.
- `rd_en`  in  1  pop head entry; ignored when empty.
- `clr_overflow`  in  1  clears `overflow`.
- `action`  out  3  head-of-FIFO action code; 0 when empty.
- `action_valid`  out  1  FIFO non-empty.
- `held`  out  6  per-action held bitmap; bit index = action code − 1.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; an enqueue was dropped because the FIFO was full.

## Operation
- Scan-code map (E0 prefix already stripped upstream): 75/1D → UP=1; 72/1B → DOWN=2; 6B/1C → LEFT=3; 74/23 → RIGHT=4; 29 → FIRE=5; 76 → PAUSE=6. Every other code maps to NONE=0 and is ignored entirely.
- Make with `held[a]`=0: set `held[a]`, enqueue `a`.
- Make with `held[a]`=1 (typematic, or alias key): no change, no enqueue.
- Break: clear `held[a]`, no enqueue. A break of an already-clear bit is a no-op.
- Enqueue when full: entry dropped, `overflow` set. When `rd_en` is asserted in the same cycle, the pop frees a slot and the write succeeds, with no overflow.
- `rd_en` on empty: no effect. `level` never underflows or exceeds `DEPTH`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are derived from `level`.
- `clr_overflow` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- Reset, also mid-operation: `held`=0, `level`=0, `action`=0, `action_valid`=0, `overflow`=0, repeat timer idle. FIFO contents are discarded.

## Timing
- Event sampled at posedge N. `held`, `level`, `action_valid` and `action` reflect it after edge N (1-cycle latency).
- Show-ahead: `action` is valid whenever `action_valid`=1. A pop at edge N presents the next entry after edge N.
- Back-to-back `valid` pulses on consecutive cycles are each processed. The upstream driver never does this; the block must not rely on that.
- Push and pop in the same cycle on an empty FIFO: the push lands, the pop is ignored, and `level`=1 after the edge.

## Configuration
- `KEY_REPEAT_EN` defined:
  - A single repeat timer tracks the most recently pressed direction (actions 1–4).
  - On an accepted make of a direction, the timer loads `REPEAT_FIRST`.
  - At zero it enqueues that action and reloads `REPEAT_NEXT`.
  - It goes idle when that direction's `held` bit clears, or when FIRE or PAUSE is pressed.
  - When a keyboard enqueue and a repeat enqueue coincide, the keyboard wins. The timer holds at zero and fires on the next cycle.
  - The timer is 24 bits wide. `REPEAT_FIRST` and `REPEAT_NEXT` must each be at least 1.
- `KEY_REPEAT_EN` undefined: no timer logic. Only keyboard makes enqueue. The repeat parameters are unused.

## Structure
- Shared package `squares_input_pkg`: action code constants (NONE…PAUSE), scan-code constants, action width 3, held-bitmap width 6.
- Sub-module `key_action_fifo`: parameterised show-ahead FIFO with push, pop, full, empty, level and a drop flag. The top level holds the decoder, the held bitmap and the repeat timer.

## Test plan
- Reset, then make 0x1D, then break 0x1D → `held`=000001 after the make, `action`=1, `action_valid`=1, `level`=1. After the break, `held`=0 and `level` is still 1.
- Make 0x75 three times with no break → exactly one entry queued. Then make 0x72 → `level`=2, entries 1 then 2 popped in order.
- With `DEPTH`=8, nine distinct make/break pairs → `level`=8, `overflow`=1. `clr_overflow` clears it. A ninth make plus `rd_en` in the same cycle → `level` stays 8, `overflow` stays 0.
- Make 0x5A (unmapped) → no change to any output.
- `KEY_REPEAT_EN`, with `REPEAT_FIRST`=10 and `REPEAT_NEXT`=4: make 0x6B at cycle 0 → enqueues at cycles 0, 10, 14, 18. Break at cycle 20 → no further entries.
- Assert `reset` low with `level`=5 and `held`≠0 → all outputs 0 asynchronously. Release, then make 0x29 → `action`=5.

Source files
------------

// File: rtl/squares_input_pkg.sv
// squares_input_pkg
// Shared definitions for the Squares keyboard input path: game action codes,
// the PS/2 scan codes that select them, and the scan-code decoder.
// Ports: none (package).
package squares_input_pkg;

    localparam int ACT_W  = 3;   // width of an action code
    localparam int HELD_W = 6;   // one held bit per non-NONE action

    typedef enum logic [ACT_W-1:0] {
        ACT_NONE  = 3'd0,
        ACT_UP    = 3'd1,
        ACT_DOWN  = 3'd2,
        ACT_LEFT  = 3'd3,
        ACT_RIGHT = 3'd4,
        ACT_FIRE  = 3'd5,
        ACT_PAUSE = 3'd6
    } action_t;

    // Scan codes arrive with any E0 prefix already stripped, so arrow keys
    // and their WASD-style aliases share the same action.
    localparam logic [7:0] SC_UP_A    = 8'h75;
    localparam logic [7:0] SC_UP_B    = 8'h1D;
    localparam logic [7:0] SC_DOWN_A  = 8'h72;
    localparam logic [7:0] SC_DOWN_B  = 8'h1B;
    localparam logic [7:0] SC_LEFT_A  = 8'h6B;
    localparam logic [7:0] SC_LEFT_B  = 8'h1C;
    localparam logic [7:0] SC_RIGHT_A = 8'h74;
    localparam logic [7:0] SC_RIGHT_B = 8'h23;
    localparam logic [7:0] SC_FIRE    = 8'h29;
    localparam logic [7:0] SC_PAUSE   = 8'h76;

    function automatic action_t decode_scan(input logic [7:0] code);
        case (code)
            SC_UP_A,    SC_UP_B:    decode_scan = ACT_UP;
            SC_DOWN_A,  SC_DOWN_B:  decode_scan = ACT_DOWN;
            SC_LEFT_A,  SC_LEFT_B:  decode_scan = ACT_LEFT;
            SC_RIGHT_A, SC_RIGHT_B: decode_scan = ACT_RIGHT;
            SC_FIRE:                decode_scan = ACT_FIRE;
            SC_PAUSE:               decode_scan = ACT_PAUSE;
            default:                decode_scan = ACT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_action_queue_if.sv
// key_action_queue_if
// Bundles the key-event input, the game-side pop/clear controls and the
// queue status outputs of key_action_queue.
//   master: drives valid/makeBreak/outCode/rd_en/clr_overflow, reads status
//   slave : the queue itself
// Parameter DEPTH sizes the level field ($clog2(DEPTH)+1 bits).
interface key_action_queue_if #(parameter int DEPTH = 8);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             valid;
    logic             makeBreak;
    logic [7:0]       outCode;
    logic             rd_en;
    logic             clr_overflow;
    logic [2:0]       action;
    logic             action_valid;
    logic [5:0]       held;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output valid, makeBreak, outCode, rd_en, clr_overflow,
        input  action, action_valid, held, level, overflow
    );

    modport slave (
        input  valid, makeBreak, outCode, rd_en, clr_overflow,
        output action, action_valid, held, level, overflow
    );

endinterface

// File: rtl/key_action_fifo.sv
// key_action_fifo
// Show-ahead FIFO: dout presents the head entry whenever the FIFO is
// non-empty (zero when empty). A pop in the same cycle as a push on a full
// FIFO frees the slot so the push is accepted.
// Ports: clk, rst_n (async active-low), push/din, pop, dout, full, empty,
//        level (occupancy), drop (a push was refused this cycle).
module key_action_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/key_action_queue.sv
// key_action_queue
// Converts PS/2 make/break events into Squares game actions, tracks which
// actions are held, and queues newly pressed actions for the game logic.
// Build option KEY_REPEAT_EN adds auto-repeat of the last pressed direction.
// Ports: CLOCK_50 (clock), reset (async active-low),
//        bus (key_action_queue_if.slave): key events in, rd_en/clr_overflow
//        in, action/action_valid/held/level/overflow out.
module key_action_queue
    import squares_input_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int REPEAT_FIRST = 12_500_000,
    parameter int REPEAT_NEXT  = 5_000_000
) (
    input logic             CLOCK_50,
    input logic             reset,
    key_action_queue_if.slave bus
);

    action_t            ev_act;
    logic [ACT_W-1:0]   ev_code;
    logic               ev_hit;
    logic [HELD_W-1:0]  ev_mask;
    logic [HELD_W-1:0]  held;
    logic               kb_push;
    logic               push;
    logic [ACT_W-1:0]   push_data;
    logic               drop;
    logic               empty;
    logic               unused_full;
    logic               overflow;

    assign ev_act  = decode_scan(bus.outCode);
    assign ev_code = ev_act;
    assign ev_hit  = bus.valid && (ev_act != ACT_NONE);

    always_comb begin
        ev_mask = '0;
        for (int i = 0; i < HELD_W; i++)
            ev_mask[i] = ev_hit && (ev_code == ACT_W'(i + 1));
    end

    // Only the first make of an action enqueues; typematic repeats and alias
    // keys of an already-held action are absorbed by the held bitmap.
    assign kb_push = ev_hit && bus.makeBreak && ((held & ev_mask) == '0);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            held <= '0;
        else if (ev_hit)
            held <= bus.makeBreak ? (held | ev_mask) : (held & ~ev_mask);
    end

`ifdef KEY_REPEAT_EN
    localparam logic [23:0] RPT_FIRST_LD = 24'(REPEAT_FIRST - 1);
    localparam logic [23:0] RPT_NEXT_LD  = 24'(REPEAT_NEXT - 1);

    logic             rpt_active;
    logic [ACT_W-1:0] rpt_act;
    logic [23:0]      rpt_cnt;
    logic             rpt_load;
    logic             rpt_stop;
    logic             rpt_fire;

    // Counter is loaded with N-1 so the repeat lands exactly N cycles after
    // the keyboard enqueue (it fires on the edge where it sits at zero).
    assign rpt_load = kb_push && (ev_act inside {ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT});
    assign rpt_stop = rpt_active && ev_hit &&
                      ((bus.makeBreak && (ev_act inside {ACT_FIRE, ACT_PAUSE})) ||
                       (!bus.makeBreak && (ev_code == rpt_act)));
    // A keyboard enqueue owns the FIFO write port; the timer waits at zero.
    assign rpt_fire = rpt_active && (rpt_cnt == '0) && !kb_push && !rpt_stop;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rpt_active <= 1'b0;
            rpt_act    <= '0;
            rpt_cnt    <= '0;
        end else if (rpt_load) begin
            rpt_active <= 1'b1;
            rpt_act    <= ev_code;
            rpt_cnt    <= RPT_FIRST_LD;
        end else if (rpt_stop) begin
            rpt_active <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt    <= RPT_NEXT_LD;
        end else if (rpt_active && (rpt_cnt != '0)) begin
            rpt_cnt    <= rpt_cnt - 1'b1;
        end
    end

    assign push      = kb_push | rpt_fire;
    assign push_data = kb_push ? ev_code : rpt_act;
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{REPEAT_FIRST, REPEAT_NEXT};

    assign push      = kb_push;
    assign push_data = ev_code;
`endif

    key_action_fifo #(
        .DEPTH (DEPTH),
        .W     (ACT_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .push  (push),
        .din   (push_data),
        .pop   (bus.rd_en),
        .dout  (bus.action),
        .full  (unused_full),
        .empty (empty),
        .level (bus.level),
        .drop  (drop)
    );

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (bus.clr_overflow)
            overflow <= 1'b0;
    end

    assign bus.action_valid = ~empty;
    assign bus.held         = held;
    assign bus.overflow     = overflow;

endmodule
